// File: rtl/apb_arbiter_if.sv
// rtl/apb_arbiter_if.sv - requester handshake and APB bus bundle for apb_arbiter
interface apb_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            write_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            done_o;
    logic [NUM_REQ-1:0]            err_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;

    modport master (
        input  req_i, write_i, addr_i, wdata_i, PRDATA, PREADY,
        output done_o, err_o, rdata_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_i, write_i, addr_i, wdata_i, PRDATA, PREADY,
        input  done_o, err_o, rdata_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin APB master arbiter with ACCESS-phase timeout
module apb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_grant_q;
    logic [GW-1:0]           winner;
    logic [GW-1:0]           cand;
    logic                    any_req;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [CW-1:0]           cnt_q;
    logic                    timed_out;
    logic                    err_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    // Walk from farthest to nearest offset so the requester closest after
    // last_grant overwrites any earlier candidate.
    always_comb begin
        winner  = last_grant_q;
        cand    = last_grant_q;
        any_req = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = GW'((int'(last_grant_q) + i) % NUM_REQ);
            if (bus.req_i[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == GW'(k)) begin
                sel_write = bus.write_i[k];
                sel_addr  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timed_out = (cnt_q + 1'b1) == CW'(TIMEOUT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.done_o  = '0;
        bus.err_o   = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = SETUP;
            end
            SETUP: begin
                bus.PSEL = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                if (bus.PREADY || timed_out) state_d = DONE;
            end
            DONE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    bus.done_o[k] = (last_grant_q == GW'(k));
                    bus.err_o[k]  = (last_grant_q == GW'(k)) && err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            cnt_q        <= '0;
            err_q        <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        last_grant_q <= winner;
                        pwrite_q     <= sel_write;
                        paddr_q      <= sel_addr;
                        pwdata_q     <= sel_wdata;
                        cnt_q        <= '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.PREADY) begin
                        rdata_q <= bus.PRDATA;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter
module tb_apb_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    apb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;

    int done_pulses = 0;
    int done_double = 0;
    int bad_en      = 0;
    logic [NR-1:0] prev_done = '0;

    always @(negedge PCLK) begin
        if (bus.done_o != '0) done_pulses++;
        if (bus.done_o != '0 && prev_done != '0) done_double++;
        if (bus.PENABLE && !bus.PSEL) bad_en++;
        prev_done = bus.done_o;
    end

    int            o_psel_cyc, o_en_cyc, o_done_cyc, o_en_cnt;
    logic [NR-1:0] o_done_vec, o_err_vec;
    logic [DW-1:0] o_rdata, o_pwdata;
    logic [AW-1:0] o_paddr;
    logic          o_pwrite, o_psel0, o_psel_done;

    function automatic int rr_pick(input int last, input logic [NR-1:0] rq);
        int idx;
        for (int i = 1; i <= NR; i++) begin
            idx = (last + i) % NR;
            if (rq[idx]) return idx;
        end
        return -1;
    endfunction

    // Drives one transfer starting in cycle 0 and records what the bus did,
    // with cycle numbers relative to the cycle in which req is first sampled.
    task automatic run_xfer(input logic [NR-1:0] rq, input logic [NR-1:0] wr,
                            input logic [NR*AW-1:0] ad, input logic [NR*DW-1:0] wd,
                            input int w, input bit tie, input logic [DW-1:0] prd,
                            input int drop_k);
        int k;
        bit fin;
        o_psel_cyc = -1; o_en_cyc = -1; o_done_cyc = -1; o_en_cnt = 0;
        o_done_vec = '0; o_err_vec = '0; o_rdata = 'x; o_paddr = 'x;
        o_pwdata = 'x; o_pwrite = 1'bx; o_psel0 = 1'bx; o_psel_done = 1'bx;
        @(posedge PCLK); #1;
        bus.req_i = rq; bus.write_i = wr; bus.addr_i = ad; bus.wdata_i = wd;
        bus.PRDATA = prd;
        k = 0; fin = 1'b0;
        while (!fin && k < 64) begin
            if (k > 0) begin
                @(posedge PCLK); #1;
            end
            if (drop_k >= 0 && k >= drop_k) bus.req_i = '0;
            bus.PREADY = tie || (w >= 0 && k >= 2 + w);
            @(negedge PCLK);
            if (k == 0) o_psel0 = bus.PSEL;
            if (bus.PSEL && o_psel_cyc < 0) begin
                o_psel_cyc = k; o_paddr = bus.PADDR; o_pwrite = bus.PWRITE; o_pwdata = bus.PWDATA;
            end
            if (bus.PENABLE) begin
                o_en_cnt++;
                if (o_en_cyc < 0) o_en_cyc = k;
            end
            if (bus.done_o != '0) begin
                o_done_cyc = k; o_done_vec = bus.done_o; o_err_vec = bus.err_o;
                o_rdata = bus.rdata_o; o_psel_done = bus.PSEL; fin = 1'b1;
            end
            k++;
        end
    endtask

    task automatic idle_cycles(input int n);
        @(posedge PCLK); #1;
        bus.req_i = '0;
        bus.PREADY = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic test_reset();
        bus.req_i = '0; bus.write_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0;
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        n_checks++; if (bus.PSEL !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %0b expected 0", bus.PSEL); end
        n_checks++; if (bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %0b expected 0", bus.PENABLE); end
        n_checks++; if (bus.done_o !== '0 || bus.err_o !== '0) begin n_fail++; $display("FAIL reset_done_err: got %b/%b expected 00/00", bus.done_o, bus.err_o); end
        n_checks++; if ({bus.rdata_o, bus.PADDR, bus.PWDATA, bus.PWRITE} !== '0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h pwrite=%b expected all 0",
                               bus.rdata_o, bus.PADDR, bus.PWDATA, bus.PWRITE);
        end
        PRESETn = 1'b1;
        model_last = NR - 1;
        @(negedge PCLK);
    endtask

    task automatic test_basic_write();
        logic [DW-1:0] prd;
        prd = $urandom;
        run_xfer(2'b01, 2'b01, {32'h0, 32'h0}, {32'h0, 32'h0000_00FF}, 0, 1'b1, prd, -1);
        n_checks++; if (o_psel_cyc !== 1) begin n_fail++; $display("FAIL wr_psel_cycle: got %0d expected 1", o_psel_cyc); end
        n_checks++; if (o_en_cyc !== 2) begin n_fail++; $display("FAIL wr_penable_cycle: got %0d expected 2", o_en_cyc); end
        n_checks++; if (o_done_cyc !== 3 || o_done_vec !== 2'b01) begin n_fail++; $display("FAIL wr_done: got cycle %0d vec %b expected cycle 3 vec 01", o_done_cyc, o_done_vec); end
        n_checks++; if (o_err_vec !== 2'b00) begin n_fail++; $display("FAIL wr_err: got %b expected 00", o_err_vec); end
        n_checks++; if (o_pwrite !== 1'b1 || o_paddr !== 32'h0 || o_pwdata !== 32'hFF) begin
            n_fail++; $display("FAIL wr_bus: got pwrite=%b paddr=%h pwdata=%h expected 1/0/ff", o_pwrite, o_paddr, o_pwdata);
        end
        model_last = 0;
        idle_cycles(2);
    endtask

    task automatic test_read_wait();
        run_xfer(2'b10, 2'b00, {32'h8, 32'h0}, '0, 1, 1'b0, 32'hA5A5_0001, -1);
        n_checks++; if (o_done_cyc !== 4 || o_done_vec !== 2'b10) begin n_fail++; $display("FAIL rd_done: got cycle %0d vec %b expected cycle 4 vec 10", o_done_cyc, o_done_vec); end
        n_checks++; if (o_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd_rdata: got %h expected a5a50001", o_rdata); end
        n_checks++; if (o_pwrite !== 1'b0 || o_paddr !== 32'h8) begin n_fail++; $display("FAIL rd_bus: got pwrite=%b paddr=%h expected 0/8", o_pwrite, o_paddr); end
        n_checks++; if (o_en_cnt !== 2) begin n_fail++; $display("FAIL rd_penable_len: got %0d expected 2", o_en_cnt); end
        model_last = 1;
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int d0, dd0;
        d0 = done_pulses; dd0 = done_double;
        for (int i = 0; i < 4; i++) begin
            run_xfer(2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, $urandom, -1);
            n_checks++; if (o_done_vec !== NR'(1 << (i % 2))) begin n_fail++; $display("FAIL b2b_grant%0d: got %b expected %b", i, o_done_vec, NR'(1 << (i % 2))); end
            n_checks++; if (o_psel0 !== 1'b0 || o_psel_done !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap%0d: got psel %b/%b expected 0/0", i, o_psel0, o_psel_done); end
            n_checks++; if (o_done_cyc !== 3) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d expected 3", i, o_done_cyc); end
        end
        model_last = 1;
        idle_cycles(2);
        n_checks++; if (done_pulses - d0 !== 4 || done_double - dd0 !== 0) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d pulses %0d long expected 4 and 0", done_pulses - d0, done_double - dd0);
        end
        n_checks++; if (bad_en !== 0) begin n_fail++; $display("FAIL penable_without_psel: got %0d expected 0", bad_en); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] prd;
        prd = $urandom | 32'h1;
        run_xfer(2'b01, 2'b00, {32'h0, 32'h40}, '0, -1, 1'b0, prd, -1);
        n_checks++; if (o_en_cnt !== TO) begin n_fail++; $display("FAIL to_penable_len: got %0d expected %0d", o_en_cnt, TO); end
        n_checks++; if (o_done_cyc !== TO + 2 || o_done_vec !== 2'b01) begin n_fail++; $display("FAIL to_done: got cycle %0d vec %b expected cycle %0d vec 01", o_done_cyc, o_done_vec, TO + 2); end
        n_checks++; if (o_err_vec !== 2'b01 || o_rdata !== '0) begin n_fail++; $display("FAIL to_err: got err %b rdata %h expected 01 and 0", o_err_vec, o_rdata); end
        model_last = 0;
        run_xfer(2'b01, 2'b00, {32'h0, 32'h44}, '0, 0, 1'b0, prd, -1);
        n_checks++; if (o_err_vec !== 2'b00 || o_rdata !== prd || o_done_cyc !== 3) begin
            n_fail++; $display("FAIL to_recover: got err %b rdata %h cycle %0d expected 00 %h 3", o_err_vec, o_rdata, o_done_cyc, prd);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        int d0;
        @(posedge PCLK); #1;
        bus.req_i = 2'b11; bus.PREADY = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        n_checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin n_fail++; $display("FAIL rst_mid_access: got psel %b penable %b expected 1/1", bus.PSEL, bus.PENABLE); end
        d0 = done_pulses;
        #1 PRESETn = 1'b0;
        #1;
        n_checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got psel %b penable %b expected 0/0", bus.PSEL, bus.PENABLE); end
        bus.req_i = '0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        n_checks++; if (done_pulses !== d0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_pulses - d0); end
        model_last = NR - 1;
        run_xfer(2'b11, 2'b00, {32'h14, 32'h10}, '0, 0, 1'b0, 32'h0, -1);
        n_checks++; if (o_done_vec !== 2'b01) begin n_fail++; $display("FAIL rst_mid_first_grant: got %b expected 01", o_done_vec); end
        model_last = 0;
        idle_cycles(2);
    endtask

    task automatic test_drop_req();
        logic [DW-1:0] prd;
        prd = $urandom;
        run_xfer(2'b10, 2'b00, {32'h20, 32'h0}, '0, 2, 1'b0, prd, 2);
        n_checks++; if (o_done_cyc !== 5 || o_done_vec !== 2'b10 || o_rdata !== prd) begin
            n_fail++; $display("FAIL drop_req: got cycle %0d vec %b rdata %h expected 5 10 %h", o_done_cyc, o_done_vec, o_rdata, prd);
        end
        model_last = 1;
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [NR-1:0]    rq, wr;
        logic [NR*AW-1:0] ad;
        logic [NR*DW-1:0] wd;
        logic [DW-1:0]    prd;
        int w, win;
        for (int i = 0; i < 12; i++) begin
            rq = NR'($urandom_range(1, 3)); wr = NR'($urandom);
            ad = {$urandom, $urandom}; wd = {$urandom, $urandom};
            prd = $urandom; w = $urandom_range(0, 3);
            win = rr_pick(model_last, rq);
            run_xfer(rq, wr, ad, wd, w, 1'b0, prd, -1);
            n_checks++; if (o_done_vec !== NR'(1 << win) || o_err_vec !== '0) begin
                n_fail++; $display("FAIL rand%0d_grant: got %b err %b expected %b err 00", i, o_done_vec, o_err_vec, NR'(1 << win));
            end
            n_checks++; if (o_psel_cyc !== 1 || o_en_cyc !== 2 || o_done_cyc !== 3 + w) begin
                n_fail++; $display("FAIL rand%0d_timing: got %0d/%0d/%0d expected 1/2/%0d", i, o_psel_cyc, o_en_cyc, o_done_cyc, 3 + w);
            end
            n_checks++; if (o_paddr !== ad[win*AW +: AW] || o_pwrite !== wr[win] || o_pwdata !== wd[win*DW +: DW] || o_rdata !== prd) begin
                n_fail++; $display("FAIL rand%0d_data: got a=%h w=%b d=%h r=%h expected a=%h w=%b d=%h r=%h", i,
                                   o_paddr, o_pwrite, o_pwdata, o_rdata, ad[win*AW +: AW], wr[win], wd[win*DW +: DW], prd);
            end
            model_last = win;
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
